// File: rtl/fifo_rd_ctrl_if.sv
// Head-of-FIFO stream between the read controller and its consumer.
// First-word-fall-through: m_data is meaningful whenever m_valid is high.
interface fifo_rd_ctrl_if #(
    parameter int P_WIDTH = 8
);
    logic [P_WIDTH-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: syncs the write pointer, fetches from a
// 1-cycle-latency BRAM into a 2-entry skid buffer, and exports a Gray read pointer.
module fifo_rd_ctrl #(
    parameter  int P_DEPTH       = 1024,
    parameter  int P_WIDTH       = 8,
    parameter  int P_SYNC_STAGES = 2,
    localparam int ADDR_BITS     = $clog2(P_DEPTH)
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic [ADDR_BITS:0]   wr_ptr_gray,
    output logic [ADDR_BITS:0]   rd_ptr_gray,
    output logic [ADDR_BITS-1:0] bram_rd_addr,
    input  logic [P_WIDTH-1:0]   bram_rd_data,
    fifo_rd_ctrl_if.master       m,
    output logic                 rd_empty,
    output logic [ADDR_BITS:0]   rd_level
);

    function automatic logic [ADDR_BITS:0] gray2bin(input logic [ADDR_BITS:0] g);
        logic [ADDR_BITS:0] b;
        b = g;
        for (int unsigned i = 1; i <= ADDR_BITS; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [ADDR_BITS:0]   sync_q [P_SYNC_STAGES];
    logic [ADDR_BITS:0]   wr_ptr_bin_sync;
    logic [ADDR_BITS:0]   rd_ptr_bin;
    logic [ADDR_BITS:0]   rd_ptr_bin_next;
    logic                 inflight;
    logic [1:0]           buf_count;
    logic [P_WIDTH-1:0]   head_q;
    logic [P_WIDTH-1:0]   tail_q;

    logic                 mem_empty;
    logic                 pop;
    logic                 issue;
    logic [2:0]           occ_after_pop;
    logic [1:0]           cnt_after_pop;
    logic [1:0]           buf_count_nxt;
    logic [P_WIDTH-1:0]   head_nxt;
    logic [P_WIDTH-1:0]   tail_nxt;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int unsigned i = 0; i < P_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int unsigned i = 1; i < P_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_ptr_bin_sync = gray2bin(sync_q[P_SYNC_STAGES-1]);
    assign mem_empty       = (rd_ptr_bin == wr_ptr_bin_sync);
    assign pop             = m.m_valid && m.m_ready;

    // Words held plus the one arriving from the BRAM must never exceed the two slots.
    assign occ_after_pop   = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign issue           = !mem_empty && (occ_after_pop < 3'd2);
    assign rd_ptr_bin_next = rd_ptr_bin + (ADDR_BITS+1)'(issue);

    always_comb begin
        head_nxt      = head_q;
        tail_nxt      = tail_q;
        cnt_after_pop = buf_count - 2'(pop);
        if (pop) begin
            head_nxt = tail_q;
        end
        // The captured word lands in the first free slot after the pop has shifted.
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                head_nxt = bram_rd_data;
            end else begin
                tail_nxt = bram_rd_data;
            end
        end
        buf_count_nxt = cnt_after_pop + 2'(inflight);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            inflight    <= 1'b0;
            buf_count   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            rd_ptr_bin  <= rd_ptr_bin_next;
            rd_ptr_gray <= rd_ptr_bin_next ^ (rd_ptr_bin_next >> 1);
            inflight    <= issue;
            buf_count   <= buf_count_nxt;
            head_q      <= head_nxt;
            tail_q      <= tail_nxt;
        end
    end

    assign bram_rd_addr = rd_ptr_bin[ADDR_BITS-1:0];
    assign m.m_data     = head_q;
    assign m.m_valid    = (buf_count != 2'd0);
    assign rd_empty     = (buf_count == 2'd0);
    assign rd_level     = wr_ptr_bin_sync - rd_ptr_bin;

endmodule
